// File: rtl/mmio_timer_serial.sv
// Memory-mapped slave holding a free-running 64-bit timer with a compare
// interrupt, plus a byte FIFO that streams stores to a UART.
module mmio_timer_serial #(
    parameter int SERIAL_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        negResetIn,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [29:0] reqAddr,
    input  logic [31:0] reqWData,
    output logic        rspValid,
    output logic [31:0] rspRData,
    output logic        rspError,
    output logic        serialValid,
    output logic [7:0]  serialData,
    input  logic        serialReady,
    output logic        timerIrq
);

    localparam int PW = $clog2(SERIAL_FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [63:0]   counter;
    logic [63:0]   compare;
    logic          irq_q;

    logic [7:0]    fifo_mem [SERIAL_FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [7:0]    held_byte;

    logic [31:0]   rdata_q;
    logic          error_q;

    logic          io;
    logic [27:0]   offset;
    logic          addr_unused;
    logic          sel_tlo;
    logic          sel_thi;
    logic          sel_clo;
    logic          sel_chi;
    logic          sel_ser;
    logic          decode_err;

    logic          accept;
    logic          wr_acc;
    logic          ser_store;
    logic          full;
    logic          push;
    logic          pop;
    logic [7:0]    push_data;
    logic [31:0]   load_data;

    // Cacheability has no meaning for registers, so that address bit is dropped.
    assign addr_unused = reqAddr[29];
    assign io          = reqAddr[28];
    assign offset      = reqAddr[27:0];

    assign sel_tlo    = io && (offset == 28'h0000000);
    assign sel_thi    = io && (offset == 28'h0000004);
    assign sel_clo    = io && (offset == 28'h0000008);
    assign sel_chi    = io && (offset == 28'h000000C);
    assign sel_ser    = io && (offset == 28'h0002000);
    assign decode_err = !(sel_tlo || sel_thi || sel_clo || sel_chi || sel_ser);

    assign reqReady  = (state == IDLE);
    assign accept    = reqValid && reqReady;
    assign wr_acc    = accept && reqWrite;
    assign ser_store = wr_acc && sel_ser;

    assign full      = (count == CW'(SERIAL_FIFO_DEPTH));
    assign pop       = (count != '0) && serialReady;
    assign push      = (ser_store && !full) || ((state == STALL) && !full);
    assign push_data = (state == STALL) ? held_byte : reqWData[7:0];

    always_comb begin
        load_data = '0;
        unique case (1'b1)
            sel_tlo: load_data = counter[31:0];
            sel_thi: load_data = counter[63:32];
            sel_clo: load_data = compare[31:0];
            sel_chi: load_data = compare[63:32];
            sel_ser: load_data = 32'(count);
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (ser_store && full) ? STALL : RESP;
                end
            end
            STALL: begin
                if (!full) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Response payload is captured at accept; stores and errors return zero.
    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            rdata_q   <= '0;
            error_q   <= 1'b0;
            held_byte <= '0;
        end else if (accept) begin
            rdata_q <= reqWrite ? 32'h0 : load_data;
            error_q <= decode_err;
            if (ser_store && full) begin
                held_byte <= reqWData[7:0];
            end
        end
    end

    assign rspValid = (state == RESP);
    assign rspRData = (state == RESP) ? rdata_q : 32'h0;
    assign rspError = (state == RESP) && error_q;

    // A software write to either half takes priority over the increment.
    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            counter <= '0;
        end else if (wr_acc && sel_tlo) begin
            counter <= {counter[63:32], reqWData};
        end else if (wr_acc && sel_thi) begin
            counter <= {reqWData, counter[31:0]};
        end else begin
            counter <= counter + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            compare <= '1;
        end else if (wr_acc && sel_clo) begin
            compare <= {compare[63:32], reqWData};
        end else if (wr_acc && sel_chi) begin
            compare <= {reqWData, compare[31:0]};
        end
    end

    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= (counter >= compare);
        end
    end

    assign timerIrq = irq_q;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign serialValid = (count != '0);
    assign serialData  = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_mmio_timer_serial.sv
// Directed bench for mmio_timer_serial: vector table for decode and
// register access, hand sequences for timer, interrupt, stall and reset.
module tb_mmio_timer_serial;

    logic        clk = 1'b0;
    logic        negResetIn;
    logic        reqValid;
    logic        reqReady;
    logic        reqWrite;
    logic [29:0] reqAddr;
    logic [31:0] reqWData;
    logic        rspValid;
    logic [31:0] rspRData;
    logic        rspError;
    logic        serialValid;
    logic [7:0]  serialData;
    logic        serialReady;
    logic        timerIrq;

    int n_cmp = 0;
    int n_bad = 0;
    int edges;
    int acc_edge;

    typedef struct {
        logic        w;
        logic [29:0] a;
        logic [31:0] d;
        logic        chk;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    mmio_timer_serial #(.SERIAL_FIFO_DEPTH(8)) dut (
        .clk         (clk),
        .negResetIn  (negResetIn),
        .reqValid    (reqValid),
        .reqReady    (reqReady),
        .reqWrite    (reqWrite),
        .reqAddr     (reqAddr),
        .reqWData    (reqWData),
        .rspValid    (rspValid),
        .rspRData    (rspRData),
        .rspError    (rspError),
        .serialValid (serialValid),
        .serialData  (serialData),
        .serialReady (serialReady),
        .timerIrq    (timerIrq)
    );

    // Clock edges seen since reset release: the timer's value absent writes.
    always @(posedge clk or negedge negResetIn) begin
        if (!negResetIn) edges <= 0;
        else edges <= edges + 1;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_access(input logic w, input logic [29:0] a,
                             input logic [31:0] d, output logic [31:0] rd,
                             output logic er, output int lat);
        int n;
        rd  = '0;
        er  = 1'b0;
        lat = 0;
        @(negedge clk);
        reqValid = 1'b1;
        reqWrite = w;
        reqAddr  = a;
        reqWData = d;
        n = 0;
        while (!reqReady && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!reqReady) begin
            check("accept timeout", reqReady, 1);
            reqValid = 1'b0;
            return;
        end
        acc_edge = edges;
        @(posedge clk);
        #1 reqValid = 1'b0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rspValid && lat < 100);
        if (!rspValid) begin
            check("response timeout", rspValid, 1);
            return;
        end
        rd = rspRData;
        er = rspError;
    endtask

    task automatic apply_reset;
        @(negedge clk);
        negResetIn  = 1'b0;
        reqValid    = 1'b0;
        serialReady = 1'b0;
        repeat (2) @(negedge clk);
        negResetIn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        int          e1;
        logic [7:0]  rx[$];

        negResetIn  = 1'b0;
        reqValid    = 1'b0;
        reqWrite    = 1'b0;
        reqAddr     = '0;
        reqWData    = '0;
        serialReady = 1'b0;

        tbl.push_back('{1'b0, 30'h0000_0000, 32'h0,        1'b1, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 30'h1000_0010, 32'h0,        1'b1, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 30'h1000_0002, 32'h0,        1'b1, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 30'h1000_0008, 32'h12345678, 1'b0, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 30'h1000_000C, 32'h9ABCDEF0, 1'b0, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 30'h1000_0008, 32'h0,        1'b1, 32'h12345678, 1'b0});
        tbl.push_back('{1'b0, 30'h3000_000C, 32'h0,        1'b1, 32'h9ABCDEF0, 1'b0});
        tbl.push_back('{1'b1, 30'h0000_0008, 32'hDEADBEEF, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 30'h1000_0009, 32'h00000001, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 30'h1000_0008, 32'h0,        1'b1, 32'h12345678, 1'b0});
        tbl.push_back('{1'b1, 30'h0000_2000, 32'h00000055, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 30'h1000_2002, 32'h00000066, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 30'h1000_2000, 32'h0,        1'b1, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 30'h1000_2004, 32'h0,        1'b1, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 30'h0000_0004, 32'hFFFFFFF0, 1'b0, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 30'h1000_0004, 32'h0,        1'b1, 32'h0,        1'b0});

        // Reset values, then a timer load accepted at cycle 10.
        apply_reset();
        check("rst reqReady", reqReady, 1);
        check("rst rspValid", rspValid, 0);
        check("rst rspError", rspError, 0);
        check("rst rspRData", rspRData, 0);
        check("rst serialValid", serialValid, 0);
        check("rst timerIrq", timerIrq, 0);
        n = 0;
        while (edges != 9 && n < 50) begin
            @(negedge clk);
            n++;
        end
        do_access(1'b0, 30'h1000_0000, 32'h0, rd, er, lat);
        check("first load latency", lat, 1);
        check("first load rdata", rd, 32'd10);
        check("first load error", er, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            do_access(tbl[i].w, tbl[i].a, tbl[i].d, rd, er, lat);
            check($sformatf("vec%0d error", i), er, tbl[i].er);
            check($sformatf("vec%0d latency", i), lat, 1);
            if (tbl[i].chk) check($sformatf("vec%0d rdata", i), rd, tbl[i].rd);
        end
        check("vec serialValid", serialValid, 0);

        // Compare interrupt at 0x40, then cleared by rewinding the timer.
        apply_reset();
        do_access(1'b1, 30'h1000_000C, 32'h0, rd, er, lat);
        check("cmp_hi error", er, 0);
        do_access(1'b1, 30'h1000_0008, 32'h40, rd, er, lat);
        check("cmp_lo error", er, 0);
        check("irq before 0x40", timerIrq, 0);
        n = 0;
        while (edges != 64 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("irq at 0x40", timerIrq, 0);
        @(negedge clk);
        check("irq after 0x40", timerIrq, 1);
        do_access(1'b1, 30'h1000_0000, 32'h0, rd, er, lat);
        e1 = acc_edge;
        check("irq held after timer write", timerIrq, 1);
        @(negedge clk);
        check("irq fall", timerIrq, 0);
        do_access(1'b0, 30'h1000_0000, 32'h0, rd, er, lat);
        check("timer_lo after rewind", rd, 32'(acc_edge - e1 - 1));
        do_access(1'b0, 30'h1000_0004, 32'h0, rd, er, lat);
        check("timer_hi after rewind", rd, 0);

        // 64-bit wrap; irq only while the counter is all ones.
        do_access(1'b1, 30'h1000_000C, 32'hFFFFFFFF, rd, er, lat);
        do_access(1'b1, 30'h1000_0008, 32'hFFFFFFFF, rd, er, lat);
        do_access(1'b1, 30'h1000_0004, 32'hFFFFFFFF, rd, er, lat);
        do_access(1'b1, 30'h1000_0000, 32'hFFFFFFFE, rd, er, lat);
        e1 = acc_edge;
        check("wrap irq +1", timerIrq, 0);
        @(negedge clk);
        check("wrap irq +2", timerIrq, 0);
        @(negedge clk);
        check("wrap irq +3", timerIrq, 1);
        @(negedge clk);
        check("wrap irq +4", timerIrq, 0);
        do_access(1'b0, 30'h1000_0004, 32'h0, rd, er, lat);
        check("wrap timer_hi", rd, 0);
        do_access(1'b0, 30'h1000_0000, 32'h0, rd, er, lat);
        check("wrap timer_lo", rd, 32'(acc_edge - (e1 + 3)));

        // Fill the FIFO, stall on the ninth byte, release with one pop.
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            do_access(1'b1, 30'h1000_2000, 32'h41 + 32'(i), rd, er, lat);
            check($sformatf("fill%0d latency", i), lat, 1);
        end
        check("fill serialValid", serialValid, 1);
        check("fill head", serialData, 8'h41);
        do_access(1'b0, 30'h1000_2000, 32'h0, rd, er, lat);
        check("fifo count 8", rd, 8);
        fork
            do_access(1'b1, 30'h1000_2000, 32'h49, rd, er, lat);
            begin
                repeat (3) @(negedge clk);
                check("stall rspValid", rspValid, 0);
                check("stall reqReady", reqReady, 0);
                @(negedge clk);
                rx.push_back(serialData);
                serialReady = 1'b1;
                @(negedge clk);
                serialReady = 1'b0;
            end
        join
        check("stalled store latency", lat, 5);
        check("stalled store error", er, 0);
        serialReady = 1'b1;
        n = 0;
        while (serialValid && n < 20) begin
            rx.push_back(serialData);
            @(negedge clk);
            n++;
        end
        serialReady = 1'b0;
        check("drain count", rx.size(), 9);
        for (int i = 0; i < rx.size(); i++)
            check($sformatf("drain byte%0d", i), rx[i], 8'h41 + 8'(i));
        do_access(1'b0, 30'h1000_2000, 32'h0, rd, er, lat);
        check("fifo count 0", rd, 0);

        // Reset while stalled drops the store without a response.
        for (int i = 0; i < 8; i++)
            do_access(1'b1, 30'h1000_2000, 32'h61 + 32'(i), rd, er, lat);
        @(negedge clk);
        reqValid = 1'b1;
        reqWrite = 1'b1;
        reqAddr  = 30'h1000_2000;
        reqWData = 32'h70;
        @(posedge clk);
        #1 reqValid = 1'b0;
        @(negedge clk);
        check("pre-reset stall", reqReady, 0);
        negResetIn = 1'b0;
        @(negedge clk);
        check("in-reset rspValid", rspValid, 0);
        check("in-reset serialValid", serialValid, 0);
        negResetIn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("post-reset rspValid%0d", i), rspValid, 0);
            check($sformatf("post-reset serialValid%0d", i), serialValid, 0);
            check($sformatf("post-reset reqReady%0d", i), reqReady, 1);
        end
        do_access(1'b0, 30'h1000_2000, 32'h0, rd, er, lat);
        check("post-reset fifo count", rd, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
